feature_vector_loader: RTL
==========================

# feature_vector_loader

Upstream feeder for `dense_layer_1`. It accepts a serial stream of signed feature samples from the feature-extraction front end over a valid/ready handshake. Each sample is scaled, rounded and saturated to the layer input width, and samples are collected into an IN_SIZE-element fill buffer. A completed frame is transferred into a stable parallel output vector, and the block pulses `layer_start`, which drives the dense layer's synchronous reset so the layer restarts its accumulation on fresh data.

## Interface
Parameters:
- IN_SIZE, 26, elements per feature frame; equals the dense layer's input count.
- DATA_WIDTH_0, 8, width of each output element (signed).
- SAMPLE_WIDTH, 16, width of each incoming sample (signed).
- SHIFT, 4, arithmetic right shift applied to each sample before saturation; legal range 0..SAMPLE_WIDTH-1.
- HOLD_CYCLES, 30, minimum number of cycles the output vector stays frozen after a `layer_start` pulse.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- s_valid  in  1  input sample valid.
- s_ready  out  1  loader can accept a sample this cycle.
- s_data  in  SAMPLE_WIDTH  signed feature sample.
- s_last  in  1  marks the final sample of a frame.
- vector_out  out  DATA_WIDTH_0 x IN_SIZE  signed parallel vector feeding the dense layer input.
- layer_start  out  1  one-cycle pulse; connected to the dense layer's reset.
- layer_done  out  1  one-cycle pulse when the hold window expires; dense layer output is valid.
- frame_err  out  1  one-cycle pulse on a framing error.

## Operation
- A transfer occurs when `s_valid && s_ready`. Samples land in `fill[idx]`, and `idx` increments on each transfer.
- Conversion per sample:
  - t = (s_data + round) >>> SHIFT, with round = 1<<(SHIFT-1) when rounding is enabled (0 when SHIFT=0).
  - t is saturated to [-2^(DATA_WIDTH_0-1), 2^(DATA_WIDTH_0-1)-1].
  - Intermediate width is SAMPLE_WIDTH+1, so the rounding add cannot overflow.
- State FILL:
  - `s_ready` = 1.
  - Normal completion: a transfer with `idx == IN_SIZE-1` and `s_last` = 1 marks the frame complete.
  - Missing `s_last` at `idx == IN_SIZE-1`: the frame still completes and `frame_err` pulses.
  - Early `s_last` (`idx < IN_SIZE-1`): remaining elements are zero-filled, the frame completes and `frame_err` pulses.
  - On completion: go to SWAP if the hold counter is 0; otherwise go to WAIT.
- State WAIT: `s_ready` = 0. Go to SWAP when the hold counter reaches 0.
- State SWAP (one cycle):
  - `s_ready` = 0.
  - `vector_out` <= fill and `layer_start` <= 1, both registered on the same edge.
  - The hold counter loads HOLD_CYCLES, `idx` clears, and the state returns to FILL.
- The hold counter decrements while it is non-zero. `layer_done` pulses on the cycle it transitions 1 -> 0.
- Filling of the next frame overlaps the current hold window (double buffering).

## Timing
- Reset values: `vector_out` all 0, `layer_start` 0, `layer_done` 0, `frame_err` 0, `s_ready` 0 during rst and 1 on the first cycle after. State resets to FILL, `idx` to 0, hold counter to 0.
- Latency from the completing transfer to `layer_start` high:
  - 1 cycle if the hold counter is 0.
  - Otherwise 1 cycle after the counter reaches 0.
- `layer_start` is high exactly 1 cycle. `vector_out` is constant from that cycle until the next SWAP, which is at least HOLD_CYCLES+1 cycles later.
- `layer_done` fires HOLD_CYCLES cycles after the `layer_start` cycle.
- `frame_err` is registered and asserted in the cycle after the offending transfer.
- rst mid-frame: the partial frame is discarded, `vector_out` is zeroed, and no `layer_start` is issued.
- A completed frame arriving in the same cycle the hold counter reaches 0 goes straight to SWAP.

## Configuration
- FEATURE_ROUND_EN defined: round-half-up before the shift (round = 1<<(SHIFT-1)).
- FEATURE_ROUND_EN undefined: plain truncating arithmetic shift (round = 0).

## Structure
- In `nn_parameters`: IN_SIZE_1, DATA_WIDTH_0, FEATURE_SAMPLE_WIDTH, FEATURE_SHIFT, LAYER1_HOLD_CYCLES, and the `loader_state_t` enum (FILL, WAIT, SWAP).
- One sub-module, `feature_quantizer`: combinational round/shift/saturate, SAMPLE_WIDTH -> DATA_WIDTH_0.

## Test plan
- Stream 26 samples, s_data = 16*k for k = 0..25, with `s_last` on the 26th (SHIFT=4) -> `vector_out[k]` = k, `layer_start` 1 cycle after the last transfer, `layer_done` 30 cycles after `layer_start`.
- Saturation (SHIFT=4):
  - s_data = 32767 -> 127.
  - s_data = -32768 -> -128.
  - s_data = 2040 -> 127.
  - s_data = -2064 -> -128.
- Rounding:
  - s_data = 24: 2 (FEATURE_ROUND_EN defined), 1 (undefined).
  - s_data = -24: -1 (defined), -2 (undefined).
- Early `s_last` on sample 10 -> elements 10..25 = 0 and `frame_err` pulses once. Missing `s_last` on sample 26 -> frame completes and `frame_err` pulses.
- Two back-to-back frames with `s_valid` held at 1 -> second `layer_start` exactly 31 cycles after the first, `s_ready` low during WAIT, first `vector_out` stable throughout the hold window.
- Assert rst after sample 13 of the second frame -> `vector_out` = 0, no `layer_start`; the next full frame behaves as the first scenario.

Source files
------------

// File: rtl/nn_parameters.sv
`default_nettype none
// ============================================================================
//  Module   : nn_parameters (package)
//  Purpose  : Shared sizing constants for the feature loader and dense layer 1,
//             plus the loader's state encoding.
//  Revision : 1.0  initial release
// ============================================================================
package nn_parameters;

  localparam int IN_SIZE_1            = 26;  // dense layer 1 input count
  localparam int DATA_WIDTH_0         = 8;   // layer input element width
  localparam int FEATURE_SAMPLE_WIDTH = 16;  // front-end sample width
  localparam int FEATURE_SHIFT        = 4;   // sample -> element scaling
  localparam int LAYER1_HOLD_CYCLES   = 30;  // layer accumulation window

  typedef enum logic [1:0] {
    FILL = 2'd0,
    WAIT = 2'd1,
    SWAP = 2'd2
  } loader_state_t;

endpackage
`default_nettype wire

// File: rtl/feature_quantizer.sv
`default_nettype none
// ============================================================================
//  Module   : feature_quantizer
//  Purpose  : Combinational scale / round / saturate of one signed sample
//             down to a signed layer element.
//  Ports    : sample (in, SAMPLE_WIDTH signed), q (out, DATA_WIDTH signed)
//  Config   : FEATURE_ROUND_EN defined   -> round half up before the shift
//             FEATURE_ROUND_EN undefined -> truncating arithmetic shift
//  Revision : 1.0  initial release
// ============================================================================
module feature_quantizer #(
  parameter int SAMPLE_WIDTH = 16,
  parameter int DATA_WIDTH   = 8,
  parameter int SHIFT        = 4
) (
  input  logic signed [SAMPLE_WIDTH-1:0] sample,
  output logic signed [DATA_WIDTH-1:0]   q
);

  // One extra bit so the rounding add can never wrap.
  localparam int EXT_W = SAMPLE_WIDTH + 1;
  localparam int RSH   = (SHIFT > 0) ? SHIFT - 1 : 0;

`ifdef FEATURE_ROUND_EN
  localparam logic signed [EXT_W-1:0] ROUND = (SHIFT > 0) ? (EXT_W'(1) << RSH) : '0;
`else
  localparam logic signed [EXT_W-1:0] ROUND = '0;
`endif

  localparam logic signed [EXT_W-1:0] MAXV = (EXT_W'(1) << (DATA_WIDTH - 1)) - EXT_W'(1);
  localparam logic signed [EXT_W-1:0] MINV = ~MAXV;

  logic signed [EXT_W-1:0] sum;
  logic signed [EXT_W-1:0] shifted;

  assign sum     = {sample[SAMPLE_WIDTH-1], sample} + ROUND;
  assign shifted = sum >>> SHIFT;

  always_comb begin
    if (shifted > MAXV)      q = MAXV[DATA_WIDTH-1:0];
    else if (shifted < MINV) q = MINV[DATA_WIDTH-1:0];
    else                     q = shifted[DATA_WIDTH-1:0];
  end

endmodule
`default_nettype wire

// File: rtl/feature_vector_loader.sv
`default_nettype none
// ============================================================================
//  Module   : feature_vector_loader
//  Purpose  : Collects a serial stream of quantized feature samples into a
//             fill buffer and swaps complete frames into a stable parallel
//             vector for dense_layer_1, pulsing layer_start (the layer reset)
//             on each swap. Filling overlaps the hold window of the previous
//             frame (double buffering).
//  Ports    : clk, rst          clock, synchronous active-high reset
//             s_valid/s_ready   sample handshake; s_data sample, s_last frame end
//             vector_out        IN_SIZE x DATA_WIDTH_0 element vector (elem 0 = LSBs)
//             layer_start       1-cycle pulse, same cycle vector_out updates
//             layer_done        1-cycle pulse HOLD_CYCLES after layer_start
//             frame_err         1-cycle pulse after an early or missing s_last
//  Config   : FEATURE_ROUND_EN selects rounding in feature_quantizer
//  Revision : 1.0  initial release
// ============================================================================
module feature_vector_loader
  import nn_parameters::*;
#(
  parameter int IN_SIZE      = IN_SIZE_1,
  parameter int DATA_WIDTH_0 = nn_parameters::DATA_WIDTH_0,
  parameter int SAMPLE_WIDTH = FEATURE_SAMPLE_WIDTH,
  parameter int SHIFT        = FEATURE_SHIFT,
  parameter int HOLD_CYCLES  = LAYER1_HOLD_CYCLES
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  s_valid,
  output logic                                  s_ready,
  input  logic signed [SAMPLE_WIDTH-1:0]        s_data,
  input  logic                                  s_last,
  output logic [IN_SIZE-1:0][DATA_WIDTH_0-1:0]  vector_out,
  output logic                                  layer_start,
  output logic                                  layer_done,
  output logic                                  frame_err
);

  localparam int IDX_W  = $clog2(IN_SIZE + 1);
  localparam int HOLD_W = $clog2(HOLD_CYCLES + 2);

  loader_state_t                       state;
  logic [IDX_W-1:0]                    idx;
  logic [HOLD_W-1:0]                   hold;
  logic [IN_SIZE-1:0][DATA_WIDTH_0-1:0] fill;
  logic [IN_SIZE-1:0][DATA_WIDTH_0-1:0] fill_next;
  logic [DATA_WIDTH_0-1:0]             q;
  logic                                xfer;
  logic                                at_end;
  logic                                complete;

  feature_quantizer #(
    .SAMPLE_WIDTH (SAMPLE_WIDTH),
    .DATA_WIDTH   (DATA_WIDTH_0),
    .SHIFT        (SHIFT)
  ) u_quant (
    .sample (s_data),
    .q      (q)
  );

  assign s_ready  = (state == FILL) && !rst;
  assign xfer     = s_valid && s_ready;
  assign at_end   = (idx == IDX_W'(IN_SIZE - 1));
  assign complete = xfer && (at_end || s_last);

  // Buffer contents after accepting the current sample: older slots kept,
  // current slot written, later slots zeroed (covers early s_last). This is
  // also what a same-cycle swap loads, so the final sample needs no extra cycle.
  always_comb begin
    fill_next = '0;
    for (int j = 0; j < IN_SIZE; j++) begin
      if (IDX_W'(j) < idx)       fill_next[j] = fill[j];
      else if (IDX_W'(j) == idx) fill_next[j] = q;
    end
  end

  // The SWAP state is the cycle in which the swapped vector and layer_start
  // are presented; the swap itself is registered on the edge entering it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= FILL;
      idx         <= '0;
      hold        <= '0;
      fill        <= '0;
      vector_out  <= '0;
      layer_start <= 1'b0;
      layer_done  <= 1'b0;
      frame_err   <= 1'b0;
    end else begin
      layer_start <= 1'b0;
      frame_err   <= 1'b0;
      layer_done  <= (hold == HOLD_W'(1));
      if (hold != '0) hold <= hold - 1'b1;

      case (state)
        FILL: begin
          if (xfer) begin
            fill      <= fill_next;
            // s_last disagreeing with the slot position is either early or missing.
            frame_err <= at_end ^ s_last;
            if (complete) begin
              idx <= '0;
              if (hold == '0) begin
                vector_out  <= fill_next;
                layer_start <= 1'b1;
                hold        <= HOLD_W'(HOLD_CYCLES);
                state       <= SWAP;
              end else begin
                state <= WAIT;
              end
            end else begin
              idx <= idx + 1'b1;
            end
          end
        end
        WAIT: begin
          if (hold == '0) begin
            vector_out  <= fill;
            layer_start <= 1'b1;
            hold        <= HOLD_W'(HOLD_CYCLES);
            state       <= SWAP;
          end
        end
        SWAP:    state <= FILL;
        default: state <= FILL;
      endcase
    end
  end

endmodule
`default_nettype wire
